// File: rtl/axi_burst_mem_responder.sv
// AXI burst memory slave: one AR or AW burst at a time; R beats start READ_LATENCY idle cycles after AR, W beats are absorbed, then B.
// R beats and B are held while rready/bready are low; wready is high for every cycle of the write data phase.
module axi_burst_mem_responder #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 64,
  parameter int MEM_WORDS_LOG = 10,
  parameter int READ_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic                  s_axi_acvalid,
  output logic [ADDR_WIDTH-1:0] s_axi_acaddr,
  output logic [3:0]            s_axi_acsnoop
);

  localparam int OFFW  = $clog2(DATA_WIDTH / 8);
  localparam int IW    = MEM_WORDS_LOG;
  localparam int DEPTH = 1 << IW;
  localparam logic [15:0] LAT_LAST = (READ_LATENCY > 0) ? 16'(READ_LATENCY - 1) : 16'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_R_WAIT, S_R_DATA, S_W_DATA, S_W_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      len_q, len_d;
  logic [1:0]      burst_q, burst_d;
  logic [7:0]      beat_q, beat_d;
  logic [15:0]     lat_q, lat_d;
  logic            err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ar_hs, aw_hs, last_beat, mem_we;
  logic [ADDR_WIDTH-1:0] a_addr, a_word;
  logic [7:0]            a_len;
  logic [1:0]            a_burst;
  logic                  a_err;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx,
                                             input logic [7:0]    len,
                                             input logic [1:0]    burst);
    logic [31:0] i32, l32, n32;
    i32 = 32'(idx);
    l32 = 32'(len);
    case (burst)
      2'b00:   n32 = i32;
      2'b10:   n32 = (i32 & ~l32) | ((i32 + 32'd1) & l32);
      default: n32 = i32 + 32'd1;
    endcase
    return n32[IW-1:0];
  endfunction

  // Address phase: a read wins over a simultaneous write.
  always_comb begin
    a_addr  = s_axi_arvalid ? s_axi_araddr  : s_axi_awaddr;
    a_len   = s_axi_arvalid ? s_axi_arlen   : s_axi_awlen;
    a_burst = s_axi_arvalid ? s_axi_arburst : s_axi_awburst;
    a_word  = a_addr >> OFFW;
    a_err   = (|(a_word >> IW)) || (a_burst == 2'b11) ||
              ((a_burst == 2'b10) && !((a_len == 8'd1) || (a_len == 8'd3) ||
                                       (a_len == 8'd7) || (a_len == 8'd15)));
    ar_hs     = s_axi_arvalid && s_axi_arready;
    aw_hs     = s_axi_awvalid && s_axi_awready;
    last_beat = (beat_q == len_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (ar_hs || aw_hs) begin
          idx_d   = a_word[IW-1:0];
          len_d   = a_len;
          burst_d = a_burst;
          beat_d  = 8'd0;
          lat_d   = 16'd0;
          err_d   = a_err;
          if (ar_hs) state_d = (READ_LATENCY > 0) ? S_R_WAIT : S_R_DATA;
          else       state_d = S_W_DATA;
        end
      end
      S_R_WAIT: begin
        if (lat_q == LAT_LAST) state_d = S_R_DATA;
        else                   lat_d   = lat_q + 16'd1;
      end
      S_R_DATA: begin
        if (s_axi_rready) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            idx_d  = next_idx(idx_q, len_q, burst_q);
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_W_DATA: begin
        if (s_axi_wvalid) begin
          // The beat count, not wlast, ends the burst; a disagreeing wlast only flags the error.
          if (s_axi_wlast != last_beat) err_d = 1'b1;
          if (last_beat) begin
            state_d = S_W_RESP;
          end else begin
            idx_d  = next_idx(idx_q, len_q, burst_q);
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_W_RESP: begin
        if (s_axi_bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = reset && (state_q == S_IDLE);
    s_axi_awready = reset && (state_q == S_IDLE) && !s_axi_arvalid;
    s_axi_rvalid  = reset && (state_q == S_R_DATA);
    s_axi_wready  = reset && (state_q == S_W_DATA);
    s_axi_bvalid  = reset && (state_q == S_W_RESP);
    s_axi_rdata   = (s_axi_rvalid && !err_q) ? mem[idx_q] : '0;
    s_axi_rresp   = (s_axi_rvalid && err_q) ? 2'b10 : 2'b00;
    s_axi_rlast   = s_axi_rvalid && last_beat;
    s_axi_bresp   = (s_axi_bvalid && err_q) ? 2'b10 : 2'b00;
    s_axi_acvalid = 1'b0;
    s_axi_acaddr  = '0;
    s_axi_acsnoop = 4'd0;
    mem_we        = s_axi_wready && s_axi_wvalid && !err_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= s_axi_wdata;
  end

endmodule

// File: doc/axi_burst_mem_responder.md
Name: axi_burst_mem_responder

Overview:
AXI-style slave memory model answering the cache/memory bus master's burst reads and writes. Accepts one AR or AW burst at a time, serves R beats after a programmable latency, absorbs W beats and returns a B response. Used as the memory end of the bus in block-level and system simulation. Also synthesizable as a small on-chip RAM.

Parameters:
DATA_WIDTH, 64, beat width in bits; power of two, at least 8.
ADDR_WIDTH, 64, byte address width.
MEM_WORDS_LOG, 10, log2 of the memory depth in DATA_WIDTH words.
READ_LATENCY, 2, idle cycles between the AR handshake and the first R beat; 0 allowed.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-low reset.
s_axi_araddr  in  ADDR_WIDTH  read burst start byte address.
s_axi_arlen  in  8  read beats minus 1.
s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
s_axi_arvalid / s_axi_arready  in / out  1 / 1  AR handshake.
s_axi_rdata  out  DATA_WIDTH  read beat data.
s_axi_rresp  out  2  00 OKAY, 10 SLVERR.
s_axi_rlast  out  1  final beat of the read burst.
s_axi_rvalid / s_axi_rready  out / in  1 / 1  R handshake.
s_axi_awaddr, s_axi_awlen, s_axi_awburst  in  ADDR_WIDTH, 8, 2  write burst attributes; same encoding as AR.
s_axi_awvalid / s_axi_awready  in / out  1 / 1  AW handshake.
s_axi_wdata  in  DATA_WIDTH  write beat data; full-word writes only.
s_axi_wlast  in  1  master's final-beat marker.
s_axi_wvalid / s_axi_wready  in / out  1 / 1  W handshake.
s_axi_bresp  out  2  write response code.
s_axi_bvalid / s_axi_bready  out / in  1 / 1  B handshake.
s_axi_acvalid  out  1  snoop request; held 0.
s_axi_acaddr  out  ADDR_WIDTH  held 0.
s_axi_acsnoop  out  4  held 0.

Behaviour:
- Reset: reset==0 at a posedge puts the FSM in IDLE and clears the beat counter, latency counter and error flag.
  - While reset is low, every ready/valid output is 0; rdata, rresp, rlast, bresp are 0.
  - Memory contents are not reset.
  - Reset mid-burst abandons the burst; no R or B is issued; words already written are kept.
- Word index = addr >> log2(DATA_WIDTH/8); low address bits are ignored.
- Error flag is set at the address handshake if either condition holds:
  - the start word index is >= 2**MEM_WORDS_LOG;
  - burst==11;
  - burst==WRAP and len+1 is not in {2,4,8,16}.
- Error effects: reads return rdata=0 and rresp=10 on every beat; writes are discarded and bresp=10.
- Next word index: FIXED holds. INCR adds 1, modulo the memory depth. WRAP = (idx & ~len) | ((idx+1) & len).
- IDLE: arready=1; awready=!arvalid, so a read wins when AR and AW are valid in the same cycle.
  - AR handshake latches addr, len and burst. Goes to R_WAIT if READ_LATENCY>0, else R_DATA.
  - AW handshake latches the same fields and goes to W_DATA.
- R_WAIT: counts READ_LATENCY cycles with rvalid=0, then goes to R_DATA.
- R_DATA: rvalid=1; rdata = mem[idx], combinational from the registered index.
  - rlast=1 when beat==len.
  - On rvalid&&rready the index and beat advance. After the last beat, go to IDLE; next AR can be accepted the following cycle.
  - rdata, rresp and rlast are held stable while rvalid&&!rready.
- W_DATA: wready=1.
  - Each wvalid beat writes mem[idx] unless the error flag is set.
  - The burst ends on beat==len regardless of wlast. wlast!=(beat==len) on any beat sets the error flag.
  - Then go to W_RESP.
- W_RESP: bvalid=1 until bready, then IDLE. Write data is visible to a read issued the cycle after the W_DATA exit.
- Beat counter is 8 bits: len=255 gives 256 beats with no overflow.
- One outstanding transaction; AR and AW are not accepted outside IDLE.

Test Plan:
- Write-then-read WRAP: AW addr 0x28, len 7, WRAP, data 0xA0..0xA7 written to words 5,6,7,0,1,2,3,4 -> bresp=00. AR with the same fields -> beats 0xA0..0xA7 in that order, rlast on beat 8, first rvalid 3 cycles after the AR handshake (READ_LATENCY=2).
- INCR backpressure: rready toggled 1,0,0,1 during a 4-beat INCR read at 0x100 -> no beat dropped or duplicated; rdata stable while stalled.
- Simultaneous AR and AW in IDLE -> AR accepted first, awready=0 that cycle; AW accepted the cycle after the read's last beat.
- Out of range: AR addr 0x2000 with MEM_WORDS_LOG=10 -> every beat rresp=10, rdata=0. AW to the same address -> bresp=10 and memory unchanged.
- Protocol error: wlast on beat 2 of a len=3 burst -> bresp=10.
- Reset: reset low during beat 3 of an 8-beat read -> next cycle rvalid=0, arready=0. After reset release, arready=1 in IDLE.
